// File: rtl/timebase_pkg.sv
// Shared types and constants for the programmable timebase.
// State encodings, counter width and the reset terminal count.
package timebase_pkg;

    localparam int CNT_W = 25;

    // 100 MHz / (2 * 25_000_000) gives a 2 Hz clk_o out of reset
    localparam logic [CNT_W-1:0] DEF_LIMIT = CNT_W'(24_999_999);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

endpackage

// File: rtl/timebase_counter.sv
// Terminal-count divider: counter, limit/shadow regs, wrap compare, clk_o.
// Ports: i_run count enable, i_clr sync clear, i_ld_lim/i_ld_shd load
// limit/shadow from i_val, i_apply copies shadow to limit on wrap;
// o_wrap (comb wrap this cycle), o_tick, o_clk, o_cnt registered.
module timebase_counter
    import timebase_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_run,
    input  logic             i_clr,
    input  logic             i_ld_lim,
    input  logic             i_ld_shd,
    input  logic             i_apply,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_wrap,
    output logic             o_tick,
    output logic             o_clk,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_lim;
    logic [CNT_W-1:0] r_shd;
    logic             r_tick;
    logic             r_clk;
    logic             w_wrap;

    // A clear (stop / idle) suppresses the wrap, so no tick on stop
    assign w_wrap = i_run & ~i_clr & (r_cnt == r_lim);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_lim  <= DEF_LIMIT;
            r_shd  <= '0;
            r_tick <= 1'b0;
            r_clk  <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (i_clr) begin
                r_cnt <= '0;
                r_clk <= 1'b0;
            end else if (w_wrap) begin
                r_cnt <= '0;
                r_clk <= ~r_clk;
            end else if (i_run) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (i_ld_lim) begin
                r_lim <= i_val;
            end else if (w_wrap & i_apply) begin
                r_lim <= r_shd;
            end
            if (i_ld_shd) begin
                r_shd <= i_val;
            end
        end
    end

    assign o_wrap = w_wrap;
    assign o_tick = r_tick;
    assign o_clk  = r_clk;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/timebase_ctrl.sv
// Timebase controller: IDLE/RUN/PAUSE FSM and terminal-count reload handshake.
// Ports: start_i/stop_i pulses, pause_i level, cfg_req_i/cfg_val_i/cfg_ack_o
// reload handshake, tick_o strobe, clk_o square wave, busy_o, cnt_o.
// Optional: TIMEBASE_ONESHOT_EN adds oneshot_i (stop after first wrap).
module timebase_ctrl
    import timebase_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             pause_i,
    input  logic             cfg_req_i,
    input  logic [CNT_W-1:0] cfg_val_i,
`ifdef TIMEBASE_ONESHOT_EN
    input  logic             oneshot_i,
`endif
    output logic             cfg_ack_o,
    output logic             tick_o,
    output logic             clk_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] cnt_o
);

    state_e r_state;
    logic   r_busy;
    logic   r_ack;
    logic   r_pend;

    logic   w_idle;
    logic   w_os_done;
    logic   w_to_idle;
    logic   w_req_ok;
    logic   w_ld_lim;
    logic   w_ld_shd;
    logic   w_clr;
    logic   w_wrap;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_to_idle = ~w_idle & (stop_i | w_os_done);

    // Req is blind for the ack cycle and while a reload is queued
    assign w_req_ok  = cfg_req_i & ~r_ack & ~r_pend;
    assign w_ld_lim  = w_req_ok & w_idle;
    assign w_ld_shd  = w_req_ok & ~w_idle & ~w_to_idle;
    assign w_clr     = w_idle | w_to_idle;

    timebase_counter u_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_run    (r_state == ST_RUN),
        .i_clr    (w_clr),
        .i_ld_lim (w_ld_lim),
        .i_ld_shd (w_ld_shd),
        .i_apply  (r_pend),
        .i_val    (cfg_val_i),
        .o_wrap   (w_wrap),
        .o_tick   (tick_o),
        .o_clk    (clk_o),
        .o_cnt    (cnt_o)
    );

`ifdef TIMEBASE_ONESHOT_EN
    logic r_os;
    logic r_os_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_os      <= 1'b0;
            r_os_done <= 1'b0;
        end else begin
            if (w_idle & start_i) begin
                r_os <= oneshot_i;
            end
            r_os_done <= w_wrap & r_os;
        end
    end

    assign w_os_done = r_os_done;
`else
    assign w_os_done = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_ack <= w_ld_lim | (w_wrap & r_pend);
            if (w_to_idle | (w_wrap & r_pend)) begin
                r_pend <= 1'b0;
            end else if (w_ld_shd) begin
                r_pend <= 1'b1;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i & ~stop_i) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_to_idle) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (pause_i) begin
                        r_state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (w_to_idle) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!pause_i) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ack_o = r_ack;
    assign busy_o    = r_busy;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Directed bench for timebase_ctrl with hand-computed expectations.
// Covers reset, reloads, wrap timing, pause, stop, limit 0, async reset.
module tb_timebase_ctrl;
    import timebase_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             start_i = 1'b0;
    logic             stop_i = 1'b0;
    logic             pause_i = 1'b0;
    logic             cfg_req_i = 1'b0;
    logic [CNT_W-1:0] cfg_val_i = '0;
`ifdef TIMEBASE_ONESHOT_EN
    logic             oneshot_i = 1'b0;
`endif
    logic             cfg_ack_o;
    logic             tick_o;
    logic             clk_o;
    logic             busy_o;
    logic [CNT_W-1:0] cnt_o;

    int n_vec = 0;
    int n_err = 0;

    timebase_ctrl dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .pause_i   (pause_i),
        .cfg_req_i (cfg_req_i),
        .cfg_val_i (cfg_val_i),
`ifdef TIMEBASE_ONESHOT_EN
        .oneshot_i (oneshot_i),
`endif
        .cfg_ack_o (cfg_ack_o),
        .tick_o    (tick_o),
        .clk_o     (clk_o),
        .busy_o    (busy_o),
        .cnt_o     (cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reload_idle(input int v);
        cfg_req_i = 1'b1;
        cfg_val_i = CNT_W'(v);
        step();
        chk("idle_ack", 32'(cfg_ack_o), 32'd1);
        cfg_req_i = 1'b0;
        step();
        chk("idle_ack_drop", 32'(cfg_ack_o), 32'd0);
    endtask

    task automatic start_run();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("start_busy", 32'(busy_o), 32'd1);
        chk("start_cnt", 32'(cnt_o), 32'd0);
    endtask

    initial begin
        // reset state
        step();
        chk("rst_cnt", 32'(cnt_o), 32'd0);
        chk("rst_tick", 32'(tick_o), 32'd0);
        chk("rst_clk", 32'(clk_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ack", 32'(cfg_ack_o), 32'd0);
        rst_i = 1'b0;

        // limit 4: ticks 5,10,15 after start, clk_o period 10
        reload_idle(4);
        start_run();
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("p4_tick", 32'(tick_o), 32'(k % 5 == 0));
            chk("p4_cnt", 32'(cnt_o), 32'(k % 5));
            chk("p4_clk", 32'(clk_o), 32'((k / 5) % 2));
        end

        // reload to 1 while running at cnt=2: applied at next wrap
        step();
        step();
        chk("rl_cnt2", 32'(cnt_o), 32'd2);
        cfg_req_i = 1'b1;
        cfg_val_i = CNT_W'(1);
        step();
        chk("rl_noack3", 32'(cfg_ack_o), 32'd0);
        step();
        chk("rl_noack4", 32'(cfg_ack_o), 32'd0);
        chk("rl_cnt4", 32'(cnt_o), 32'd4);
        step();
        chk("rl_ack", 32'(cfg_ack_o), 32'd1);
        chk("rl_tick", 32'(tick_o), 32'd1);
        chk("rl_clk", 32'(clk_o), 32'd0);
        cfg_req_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("p1_tick", 32'(tick_o), 32'(k % 2 == 0));
            chk("p1_cnt", 32'(cnt_o), 32'(k % 2));
            chk("p1_ack", 32'(cfg_ack_o), 32'd0);
        end

        // stop+start with reload pending: IDLE, no ack, req serviced next
        cfg_req_i = 1'b1;
        cfg_val_i = CNT_W'(4);
        step();
        chk("sp_cnt1", 32'(cnt_o), 32'd1);
        stop_i = 1'b1;
        start_i = 1'b1;
        step();
        stop_i = 1'b0;
        start_i = 1'b0;
        chk("sp_busy", 32'(busy_o), 32'd0);
        chk("sp_cnt", 32'(cnt_o), 32'd0);
        chk("sp_clk", 32'(clk_o), 32'd0);
        chk("sp_tick", 32'(tick_o), 32'd0);
        chk("sp_noack", 32'(cfg_ack_o), 32'd0);
        step();
        chk("sp_idle_ack", 32'(cfg_ack_o), 32'd1);
        chk("sp_idle_busy", 32'(busy_o), 32'd0);
        cfg_req_i = 1'b0;
        step();

        // pause 7 cycles, frozen at 3, tick 2 cycles after release
        start_run();
        step();
        step();
        chk("ps_cnt2", 32'(cnt_o), 32'd2);
        pause_i = 1'b1;
        step();
        chk("ps_cnt3", 32'(cnt_o), 32'd3);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("ps_frz_cnt", 32'(cnt_o), 32'd3);
            chk("ps_frz_tick", 32'(tick_o), 32'd0);
        end
        chk("ps_busy", 32'(busy_o), 32'd1);
        pause_i = 1'b0;
        step();
        chk("ps_rel_cnt", 32'(cnt_o), 32'd3);
        step();
        chk("ps_rel_cnt4", 32'(cnt_o), 32'd4);
        chk("ps_rel_tick0", 32'(tick_o), 32'd0);
        step();
        chk("ps_rel_tick", 32'(tick_o), 32'd1);
        chk("ps_rel_wrap", 32'(cnt_o), 32'd0);

        // limit 0: tick every cycle, clk_o toggles every cycle
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        reload_idle(0);
        start_run();
        chk("l0_clk0", 32'(clk_o), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("l0_tick", 32'(tick_o), 32'd1);
            chk("l0_clk", 32'(clk_o), 32'(k % 2));
            chk("l0_cnt", 32'(cnt_o), 32'd0);
        end

        // asynchronous reset mid-run restores default limit
        rst_i = 1'b1;
        #1;
        chk("ar_busy", 32'(busy_o), 32'd0);
        chk("ar_tick", 32'(tick_o), 32'd0);
        chk("ar_cnt", 32'(cnt_o), 32'd0);
        rst_i = 1'b0;
        start_run();
        step();
        step();
        step();
        chk("ar_deflim_cnt", 32'(cnt_o), 32'd3);
        chk("ar_deflim_tick", 32'(tick_o), 32'd0);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;

`ifdef TIMEBASE_ONESHOT_EN
        // one-shot, limit 3: single tick at 4, idle from 5
        reload_idle(3);
        oneshot_i = 1'b1;
        start_run();
        oneshot_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("os_tick", 32'(tick_o), 32'(k == 4));
            chk("os_busy", 32'(busy_o), 32'(k <= 4));
        end
        chk("os_clk", 32'(clk_o), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
